// File: rtl/xadac_if.sv
// Shared xadac types and the decode/execute handshake interface between the
// vector register-file stage (mst) and an execution unit (slv).
package xadac_pkg;

  localparam int unsigned VecDataW = 64;
  localparam int unsigned IdW      = 4;
  localparam int unsigned NumVs    = 3;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [31:0]    instr;
  } dec_req_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic             accept;
    logic             rd_clobber;
    logic             vd_clobber;
    logic [NumVs-1:0] vs_read;
  } dec_rsp_t;

  typedef struct packed {
    logic [IdW-1:0]                   id;
    logic [31:0]                      instr;
    logic [NumVs-1:0][VecDataW-1:0]   vs_data;
  } exe_req_t;

  typedef struct packed {
    logic [IdW-1:0]      id;
    logic [4:0]          vd_addr;
    logic [VecDataW-1:0] vd_data;
    logic                vd_write;
  } exe_rsp_t;

endpackage

interface xadac_if;
  import xadac_pkg::*;

  logic     dec_req_valid;
  logic     dec_req_ready;
  dec_req_t dec_req;
  logic     dec_rsp_valid;
  logic     dec_rsp_ready;
  dec_rsp_t dec_rsp;
  logic     exe_req_valid;
  logic     exe_req_ready;
  exe_req_t exe_req;
  logic     exe_rsp_valid;
  logic     exe_rsp_ready;
  exe_rsp_t exe_rsp;

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_vaddu.sv
// Lane-wise vector add/subtract unit: registered decode slot plus a fixed-latency
// execute pipeline feeding an in-order response FIFO under credit flow control.
module xadac_vaddu #(
  parameter int unsigned ElemWidth = 8,
  parameter int unsigned Latency   = 2,
  parameter int unsigned RspDepth  = 4
) (
  input logic  clk,
  input logic  rstn,
  xadac_if.slv slv
);
  import xadac_pkg::*;

  localparam int unsigned Lanes = VecDataW / ElemWidth;
  localparam int unsigned PtrW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntW  = $clog2(RspDepth + 1);
  localparam int unsigned InfW  = $clog2(RspDepth + Latency + 1);
  localparam logic [6:0]  OpCustom0 = 7'b0001011;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  dec_rsp_t   dec_rsp_q, dec_rsp_d, dec_rsp_new;
  logic       dec_rsp_valid_q, dec_rsp_valid_d;
  logic       dec_req_ready, dec_fire;
  logic [2:0] dec_funct3;

  assign dec_req_ready     = !dec_rsp_valid_q || slv.dec_rsp_ready;
  assign dec_fire          = slv.dec_req_valid && dec_req_ready;
  assign dec_funct3        = slv.dec_req.instr[14:12];
  assign slv.dec_req_ready = dec_req_ready;
  assign slv.dec_rsp_valid = dec_rsp_valid_q;
  assign slv.dec_rsp       = dec_rsp_q;

  always_comb begin
    dec_rsp_new    = '0;
    dec_rsp_new.id = slv.dec_req.id;
    if (slv.dec_req.instr[6:0] == OpCustom0 &&
        (dec_funct3 == 3'b000 || dec_funct3 == 3'b001)) begin
      dec_rsp_new.accept     = 1'b1;
      dec_rsp_new.vd_clobber = 1'b1;
      dec_rsp_new.vs_read[0] = 1'b1;
      dec_rsp_new.vs_read[1] = 1'b1;
    end
  end

  always_comb begin
    dec_rsp_d       = dec_rsp_q;
    dec_rsp_valid_d = dec_rsp_valid_q;
    if (dec_fire) begin
      dec_rsp_d       = dec_rsp_new;
      dec_rsp_valid_d = 1'b1;
    end else if (slv.dec_rsp_ready) begin
      dec_rsp_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Execute datapath
  // ---------------------------------------------------------------------------
  logic [VecDataW-1:0] vs_a, vs_b, sum_vec, diff_vec;
  logic [2:0]          exe_funct3;
  exe_rsp_t            exe_new;
  logic                exe_req_ready, exe_fire;

  assign vs_a       = slv.exe_req.vs_data[0];
  assign vs_b       = slv.exe_req.vs_data[1];
  assign exe_funct3 = slv.exe_req.instr[14:12];
  assign exe_fire   = slv.exe_req_valid && exe_req_ready;

  // Per-lane arithmetic keeps carries/borrows from crossing lane boundaries.
  always_comb begin
    sum_vec  = '0;
    diff_vec = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      sum_vec[i*ElemWidth +: ElemWidth]  = vs_a[i*ElemWidth +: ElemWidth] +
                                           vs_b[i*ElemWidth +: ElemWidth];
      diff_vec[i*ElemWidth +: ElemWidth] = vs_a[i*ElemWidth +: ElemWidth] -
                                           vs_b[i*ElemWidth +: ElemWidth];
    end
  end

  always_comb begin
    exe_new         = '0;
    exe_new.id      = slv.exe_req.id;
    exe_new.vd_addr = slv.exe_req.instr[11:7];
    case (exe_funct3)
      3'b000: begin
        exe_new.vd_write = 1'b1;
        exe_new.vd_data  = sum_vec;
      end
      3'b001: begin
        exe_new.vd_write = 1'b1;
        exe_new.vd_data  = diff_vec;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fixed-latency pipeline (never stalls)
  // ---------------------------------------------------------------------------
  logic     pipe_valid_q [Latency];
  logic     pipe_valid_d [Latency];
  exe_rsp_t pipe_q       [Latency];
  exe_rsp_t pipe_d       [Latency];

  always_comb begin
    pipe_valid_d[0] = exe_fire;
    pipe_d[0]       = exe_new;
    for (int unsigned s = 1; s < Latency; s++) begin
      pipe_valid_d[s] = pipe_valid_q[s-1];
      pipe_d[s]       = pipe_q[s-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO and credit accounting
  // ---------------------------------------------------------------------------
  exe_rsp_t        fifo_q [RspDepth];
  exe_rsp_t        fifo_d [RspDepth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [InfW-1:0] inflight;
  logic            push, pop, rsp_valid;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign push      = pipe_valid_q[Latency-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && slv.exe_rsp_ready;

  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      fifo_d[wptr_q] = pipe_q[Latency-1];
      wptr_d         = ptr_inc(wptr_q);
      cnt_d          = cnt_d + CntW'(1);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
      cnt_d  = cnt_d - CntW'(1);
    end
  end

  always_comb begin
    inflight = InfW'(cnt_q);
    for (int unsigned s = 0; s < Latency; s++) begin
      inflight = inflight + InfW'(pipe_valid_q[s]);
    end
  end

  // Admitting only against a guaranteed FIFO slot lets the pipeline run unstalled.
  assign exe_req_ready     = (inflight < InfW'(RspDepth)) ||
                             ((inflight == InfW'(RspDepth)) && pop);
  assign slv.exe_req_ready = exe_req_ready;
  assign slv.exe_rsp_valid = rsp_valid;
  assign slv.exe_rsp       = fifo_q[rptr_q];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dec_rsp_q       <= '0;
      dec_rsp_valid_q <= 1'b0;
      for (int unsigned s = 0; s < Latency; s++) begin
        pipe_valid_q[s] <= 1'b0;
        pipe_q[s]       <= '0;
      end
      for (int unsigned e = 0; e < RspDepth; e++) begin
        fifo_q[e] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      dec_rsp_q       <= dec_rsp_d;
      dec_rsp_valid_q <= dec_rsp_valid_d;
      pipe_valid_q    <= pipe_valid_d;
      pipe_q          <= pipe_d;
      fifo_q          <= fifo_d;
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      cnt_q           <= cnt_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{slv.dec_req.instr[31:15], slv.dec_req.instr[11:7],
                         slv.exe_req.instr[31:15], slv.exe_req.instr[6:0],
                         slv.exe_req.vs_data[NumVs-1:2]};

endmodule
